// File: rtl/sprom_arbiter.sv
// Purpose: shares one registered-address single-port ROM between NREQ requesters.
// Latency: grant is combinational (same cycle); rvalid/rdata follow the grant by 1 cycle.
// Backpressure: requesters hold req/addr until gnt. The loser waits. Ports >=1 that wait
//   MAX_WAIT cycles pre-empt port 0.
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   req, addr      per-port request and packed addresses (port i at [i*WIDTHAD +: WIDTHAD])
//   gnt            one-hot grant, same cycle as the accepted request
//   rom_addr       to the ROM address pin; holds the last granted address when idle
//   rom_q          ROM data output (one cycle after the address)
//   rvalid, rdata  one-hot response strobe and the ROM data passthrough
module sprom_arbiter #(
  parameter int WIDTH    = 8,
  parameter int WIDTHAD  = 12,
  parameter int NREQ     = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTHAD-1:0] addr,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTHAD-1:0]      rom_addr,
  input  logic [WIDTH-1:0]        rom_q,
  output logic [NREQ-1:0]         rvalid,
  output logic [WIDTH-1:0]        rdata
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
  localparam logic [IW-1:0] PTR_FIRST = IW'(1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NREQ - 1);

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WIDTHAD-1:0] last_addr_q, last_addr_d;
  logic [NREQ-1:0]    rvalid_q;
  logic [CW-1:0]      wait_cnt_q [NREQ];
  logic [CW-1:0]      wait_cnt_d [NREQ];

  logic [IW-1:0]      scan_idx [NREQ-1];
  logic               starv_hit, rr_hit, win_vld;
  logic [IW-1:0]      starv_idx, rr_idx, win_idx;

  // Round-robin visiting order over ports 1..NREQ-1, starting at rr_ptr and
  // wrapping from NREQ-1 back to 1 (port 0 is never part of the rotation).
  always_comb begin
    for (int k = 0; k < NREQ - 1; k++) begin
      if (int'(rr_ptr_q) + k > NREQ - 1) begin
        scan_idx[k] = IW'(int'(rr_ptr_q) + k - (NREQ - 1));
      end else begin
        scan_idx[k] = IW'(int'(rr_ptr_q) + k);
      end
    end
  end

  // Winner selection: starved ports first, then port 0, then ordinary round-robin.
  always_comb begin
    starv_hit = 1'b0;
    starv_idx = '0;
    rr_hit    = 1'b0;
    rr_idx    = '0;
    for (int k = 0; k < NREQ - 1; k++) begin
      if (!starv_hit && req[scan_idx[k]] && wait_cnt_q[scan_idx[k]] == WAIT_MAX) begin
        starv_hit = 1'b1;
        starv_idx = scan_idx[k];
      end
      if (!rr_hit && req[scan_idx[k]]) begin
        rr_hit = 1'b1;
        rr_idx = scan_idx[k];
      end
    end

    win_vld = 1'b0;
    win_idx = '0;
    if (reset) begin
      win_vld = 1'b0;
    end else if (starv_hit) begin
      win_vld = 1'b1;
      win_idx = starv_idx;
    end else if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end else if (rr_hit) begin
      win_vld = 1'b1;
      win_idx = rr_idx;
    end

    gnt = '0;
    if (win_vld) gnt[win_idx] = 1'b1;

    // Holding the last address while idle keeps the ROM address pins quiet.
    rom_addr = last_addr_q;
    if (win_vld) rom_addr = addr[int'(win_idx)*WIDTHAD +: WIDTHAD];
  end

  // Next-state for pointer, address hold register and per-port wait counters.
  always_comb begin
    last_addr_d = rom_addr;

    rr_ptr_d = rr_ptr_q;
    if (win_vld && win_idx != '0) begin
      rr_ptr_d = (win_idx == PTR_LAST) ? PTR_FIRST : win_idx + PTR_FIRST;
    end

    wait_cnt_d[0] = '0;
    for (int i = 1; i < NREQ; i++) begin
      if (req[i] && !gnt[i]) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_MAX) ? WAIT_MAX : wait_cnt_q[i] + WAIT_ONE;
      end else begin
        wait_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= PTR_FIRST;
      last_addr_q <= '0;
      rvalid_q    <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_addr_q <= last_addr_d;
      rvalid_q    <= gnt;
      for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

  // A response in flight when reset rises is dropped in that same cycle.
  assign rvalid = reset ? '0 : rvalid_q;
  assign rdata  = rom_q;

endmodule

// File: tb/tb_sprom_arbiter.sv
module tb_sprom_arbiter;

  localparam int WIDTH    = 8;
  localparam int WIDTHAD  = 12;
  localparam int NREQ     = 4;
  localparam int MAX_WAIT = 15;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTHAD-1:0] addr;
  logic [NREQ-1:0]         gnt;
  logic [WIDTHAD-1:0]      rom_addr;
  logic [WIDTH-1:0]        rom_q;
  logic [NREQ-1:0]         rvalid;
  logic [WIDTH-1:0]        rdata;

  logic [WIDTH-1:0]        mem [1 << WIDTHAD];

  typedef struct packed {
    logic [NREQ-1:0]  rv;
    logic [WIDTH-1:0] rd;
  } exp_t;

  exp_t               sb[$];
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [WIDTHAD-1:0] exp_last;

  sprom_arbiter #(
    .WIDTH(WIDTH), .WIDTHAD(WIDTHAD), .NREQ(NREQ), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt),
    .rom_addr(rom_addr), .rom_q(rom_q), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Registered-address ROM, one cycle of read latency.
  always @(posedge clk) rom_q <= mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_addr(input logic [WIDTHAD-1:0] a0, input logic [WIDTHAD-1:0] a1,
                          input logic [WIDTHAD-1:0] a2, input logic [WIDTHAD-1:0] a3);
    addr = {a3, a2, a1, a0};
  endtask

  // One clock cycle: drive, check grant/address and the response due from the
  // previous cycle, then queue the response this cycle's grant should produce.
  task automatic cyc(input logic rst, input logic [NREQ-1:0] r, input int ep);
    logic [NREQ-1:0]    eg;
    logic [WIDTHAD-1:0] ea;
    exp_t               e;
    reset = rst;
    req   = r;
    eg    = '0;
    ea    = exp_last;
    if (ep >= 0) begin
      eg[ep] = 1'b1;
      ea     = addr[ep*WIDTHAD +: WIDTHAD];
    end
    @(negedge clk);
    check_eq("gnt", {28'd0, gnt}, {28'd0, eg});
    if (!rst) check_eq("rom_addr", {20'd0, rom_addr}, {20'd0, ea});
    if (sb.size() == 0) begin
      check_eq("rvalid_first", {28'd0, rvalid}, 32'd0);
    end else begin
      e = sb.pop_front();
      if (rst) begin
        check_eq("rvalid_in_reset", {28'd0, rvalid}, 32'd0);
      end else begin
        check_eq("rvalid", {28'd0, rvalid}, {28'd0, e.rv});
        if (e.rv != '0) check_eq("rdata", {24'd0, rdata}, {24'd0, e.rd});
      end
    end
    e.rv = eg;
    e.rd = mem[ea];
    sb.push_back(e);
    exp_last = rst ? '0 : ea;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << WIDTHAD); i++) mem[i] = WIDTH'((i * 37 + 11) & 8'hFF);
    mem[12'h123] = 8'h5A;
    reset    = 1'b1;
    req      = '0;
    addr     = '0;
    exp_last = '0;
    @(posedge clk);
    #1;

    // Reset: grants suppressed even with requests present.
    cyc(1'b1, 4'b0011, -1);
    cyc(1'b1, 4'b0000, -1);

    // Round-robin among ports 1..3 with port 0 idle.
    set_addr(12'h000, 12'h101, 12'h202, 12'h303);
    for (int c = 0; c < 9; c++) cyc(1'b0, 4'b1110, 1 + (c % 3));
    cyc(1'b0, 4'b0000, -1);

    // Single port read, then idle hold at 0x0AA.
    set_addr(12'h000, 12'h123, 12'h000, 12'h000);
    cyc(1'b0, 4'b0010, 1);
    set_addr(12'h0AA, 12'h000, 12'h000, 12'h000);
    cyc(1'b0, 4'b0001, 0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 4'b0000, -1);

    // Streaming: port 0 reads 0..7 back-to-back.
    for (int i = 0; i < 8; i++) begin
      set_addr(WIDTHAD'(i), 12'h000, 12'h000, 12'h000);
      cyc(1'b0, 4'b0001, 0);
    end
    cyc(1'b0, 4'b0000, -1);

    // Reset during an outstanding read drops the response.
    set_addr(12'h000, 12'h123, 12'h000, 12'h000);
    cyc(1'b0, 4'b0010, 1);
    cyc(1'b1, 4'b0000, -1);
    cyc(1'b1, 4'b0000, -1);
    cyc(1'b0, 4'b0000, -1);

    // Contention between port 0 and port 1: port 1 wins every 16th cycle.
    set_addr(12'h010, 12'h200, 12'h000, 12'h000);
    for (int c = 1; c <= 40; c++) cyc(1'b0, 4'b0011, (c % 16 == 0) ? 1 : 0);
    cyc(1'b0, 4'b0000, -1);

    // Simultaneous starvation of ports 1..3, rr_ptr starts at 2.
    set_addr(12'h011, 12'h211, 12'h311, 12'h3FF);
    for (int c = 1; c <= 40; c++) begin
      int ep;
      ep = 0;
      if (c >= 16 && c % 16 == 0) ep = 2;
      else if (c >= 17 && c % 16 == 1) ep = 3;
      else if (c >= 18 && c % 16 == 2) ep = 1;
      cyc(1'b0, 4'b1111, ep);
    end
    cyc(1'b0, 4'b0000, -1);

    // Withdrawing a request clears its wait count.
    set_addr(12'h020, 12'h220, 12'h000, 12'h000);
    for (int c = 1; c <= 10; c++) cyc(1'b0, 4'b0011, 0);
    cyc(1'b0, 4'b0001, 0);
    for (int c = 1; c <= 16; c++) cyc(1'b0, 4'b0011, (c == 16) ? 1 : 0);
    cyc(1'b0, 4'b0000, -1);
    cyc(1'b0, 4'b0000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
